// File: rtl/vx_vec_lane_sequencer.sv
// Splits issued instructions into per-lane dispatch packets behind one registered output slot.
// Optional perf counters are built only when VX_VEC_SEQ_PERF_EN is defined; otherwise perf_* read 0.
module vx_vec_lane_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = $clog2(NUM_LANES),
  parameter int DATA_W    = 64,
  parameter int NR_W      = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_is_vec,
  input  logic [NR_W-1:0]   in_vd,
  input  logic [LANE_W:0]   in_vl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_is_vec,
  output logic [NR_W-1:0]   out_vd,
  output logic [LANE_W-1:0] out_vd_lane_id,
  output logic              out_vd_is_last,
  output logic              busy,
  output logic [31:0]       perf_vec_instrs,
  output logic [31:0]       perf_stall_cycles
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // driver raising valid keeps its fields stable until that edge.
  typedef enum logic {S_IDLE = 1'b0, S_SEQ = 1'b1} state_e;

  localparam logic [LANE_W:0] VL_MAX = (LANE_W + 1)'(NUM_LANES);
  localparam logic [LANE_W:0] ONE    = (LANE_W + 1)'(1);

  state_e              state_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_is_vec_q;
  logic [NR_W-1:0]     out_vd_q;
  logic [LANE_W-1:0]   out_lane_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [NR_W-1:0]     hold_vd_q;
  logic [LANE_W:0]     hold_vl_q;
  logic [LANE_W:0]     lane_cnt_q;

  logic            slot_free_d;
  logic            accept_d;
  logic [LANE_W:0] vl_d;
  logic            last_lane_d;

  assign slot_free_d = !out_valid_q || out_ready;
  assign in_ready    = reset_n && (state_q == S_IDLE) && slot_free_d;
  assign accept_d    = in_valid && in_ready;
  assign vl_d        = (in_vl > VL_MAX) ? VL_MAX : in_vl;
  assign last_lane_d = (lane_cnt_q == (hold_vl_q - ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_is_vec_q <= 1'b0;
      out_vd_q     <= '0;
      out_lane_q   <= '0;
      out_last_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_vd_q    <= '0;
      hold_vl_q    <= '0;
      lane_cnt_q   <= '0;
    end else begin
      // A consumed slot empties unless something reloads it below.
      if (slot_free_d) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d && (!in_is_vec || vl_d != '0)) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= in_data;
            out_is_vec_q <= in_is_vec;
            out_vd_q     <= in_vd;
            out_lane_q   <= '0;
            out_last_q   <= !in_is_vec || (vl_d == ONE);
            if (in_is_vec && vl_d > ONE) begin
              hold_data_q <= in_data;
              hold_vd_q   <= in_vd;
              hold_vl_q   <= vl_d;
              lane_cnt_q  <= ONE;
              state_q     <= S_SEQ;
            end
          end
        end
        S_SEQ: begin
          if (slot_free_d) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= hold_data_q;
            out_is_vec_q <= 1'b1;
            out_vd_q     <= hold_vd_q;
            out_lane_q   <= lane_cnt_q[LANE_W-1:0];
            out_last_q   <= last_lane_d;
            if (last_lane_d) state_q <= S_IDLE;
            else             lane_cnt_q <= lane_cnt_q + ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_is_vec     = out_is_vec_q;
  assign out_vd         = out_vd_q;
  assign out_vd_lane_id = out_lane_q;
  assign out_vd_is_last = out_last_q;
  assign busy           = (state_q == S_SEQ);

`ifdef VX_VEC_SEQ_PERF_EN
  logic [31:0] perf_vec_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_vec_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept_d && in_is_vec && vl_d != '0) perf_vec_q <= perf_vec_q + 32'd1;
      if (out_valid_q && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_vec_instrs   = perf_vec_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_vec_instrs   = 32'd0;
  assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_vx_vec_lane_sequencer.sv
// Directed bench for vx_vec_lane_sequencer: scalar pass-through, lane splitting,
// back-pressure, vl edge cases, clamping and asynchronous abort.
module tb_vx_vec_lane_sequencer;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int DATA_W    = 64;
  localparam int NR_W      = 6;
`ifdef VX_VEC_SEQ_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_is_vec;
  logic [NR_W-1:0]   in_vd;
  logic [LANE_W:0]   in_vl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_is_vec;
  logic [NR_W-1:0]   out_vd;
  logic [LANE_W-1:0] out_vd_lane_id;
  logic              out_vd_is_last;
  logic              busy;
  logic [31:0]       perf_vec_instrs;
  logic [31:0]       perf_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_vec  = 0;
  int exp_stall = 0;

  vx_vec_lane_sequencer #(
    .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .DATA_W(DATA_W), .NR_W(NR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_is_vec(in_is_vec), .in_vd(in_vd), .in_vl(in_vl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_vec(out_is_vec), .out_vd(out_vd), .out_vd_lane_id(out_vd_lane_id),
    .out_vd_is_last(out_vd_is_last), .busy(busy),
    .perf_vec_instrs(perf_vec_instrs), .perf_stall_cycles(perf_stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic vec, input logic [63:0] data,
                       input logic [NR_W-1:0] vd, input logic [LANE_W:0] vl);
    in_valid  = v;
    in_is_vec = vec;
    in_data   = data;
    in_vd     = vd;
    in_vl     = vl;
  endtask

  task automatic check_out(input string tag, input logic [63:0] data, input logic vec,
                           input logic [NR_W-1:0] vd, input logic [LANE_W-1:0] lane,
                           input logic last);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".data"},  out_data, data);
    check({tag, ".isvec"}, out_is_vec, vec);
    check({tag, ".vd"},    out_vd, vd);
    check({tag, ".lane"},  out_vd_lane_id, lane);
    check({tag, ".last"},  out_vd_is_last, last);
  endtask

  task automatic check_perf(input string tag);
    check({tag, ".perf_vec"},   perf_vec_instrs,   PERF_EN ? exp_vec : 0);
    check({tag, ".perf_stall"}, perf_stall_cycles, PERF_EN ? exp_stall : 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"},    out_valid, 1'b0);
    check({tag, ".in_ready"}, in_ready, 1'b0);
    check({tag, ".busy"},     busy, 1'b0);
    check({tag, ".data"},     out_data, 64'd0);
    check({tag, ".vd"},       out_vd, 64'd0);
    check({tag, ".isvec"},    out_is_vec, 1'b0);
    check({tag, ".lane"},     out_vd_lane_id, 64'd0);
    check({tag, ".last"},     out_vd_is_last, 1'b0);
    check_perf(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    #2;
    check_reset_state("reset");
    cycle();
    cycle();
    reset_n = 1'b1;
    #1;
    check("post_reset.in_ready", in_ready, 1'b1);

    // three back-to-back scalars, vl ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 64'h100 + 64'(i), 6'(i + 1), 3'd3);
      #1;
      check($sformatf("scalar%0d.in_ready", i), in_ready, 1'b1);
      cycle();
      check_out($sformatf("scalar%0d", i), 64'h100 + 64'(i), 1'b0, 6'(i + 1), 2'd0, 1'b1);
      check($sformatf("scalar%0d.busy", i), busy, 1'b0);
    end
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    cycle();
    check("scalar_drain.valid", out_valid, 1'b0);

    // vl=4, vd=5 with a scalar waiting behind it
    drive(1'b1, 1'b1, 64'hA0, 6'd5, 3'd4);
    #1;
    check("vec4.accept_ready", in_ready, 1'b1);
    cycle();
    exp_vec++;
    drive(1'b1, 1'b0, 64'hB0, 6'd7, 3'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_out($sformatf("vec4.lane%0d", k), 64'hA0, 1'b1, 6'd5, 2'(k), k == 3);
      check($sformatf("vec4.lane%0d.busy", k), busy, k < 3);
      check($sformatf("vec4.lane%0d.in_ready", k), in_ready, k == 3);
      cycle();
    end
    check_out("vec4.next_scalar", 64'hB0, 1'b0, 6'd7, 2'd0, 1'b1);
    check_perf("vec4");
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    cycle();
    check("vec4_drain.valid", out_valid, 1'b0);

    // vl=3 with two stalled cycles on lane 1
    drive(1'b1, 1'b1, 64'hC0, 6'd9, 3'd3);
    cycle();
    exp_vec++;
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    check_out("vec3.lane0", 64'hC0, 1'b1, 6'd9, 2'd0, 1'b0);
    cycle();
    check_out("vec3.lane1", 64'hC0, 1'b1, 6'd9, 2'd1, 1'b0);
    out_ready = 1'b0;
    cycle();
    exp_stall++;
    check_out("vec3.hold1", 64'hC0, 1'b1, 6'd9, 2'd1, 1'b0);
    cycle();
    exp_stall++;
    check_out("vec3.hold2", 64'hC0, 1'b1, 6'd9, 2'd1, 1'b0);
    check("vec3.hold2.busy", busy, 1'b1);
    out_ready = 1'b1;
    check_perf("vec3.stalled");
    cycle();
    check_out("vec3.lane2", 64'hC0, 1'b1, 6'd9, 2'd2, 1'b1);
    check("vec3.lane2.busy", busy, 1'b0);
    cycle();
    check("vec3_drain.valid", out_valid, 1'b0);
    check_perf("vec3.done");

    // vl=0 is swallowed, vl=1 gives a single last lane
    drive(1'b1, 1'b1, 64'hD0, 6'd2, 3'd0);
    #1;
    check("vl0.in_ready", in_ready, 1'b1);
    cycle();
    check("vl0.valid", out_valid, 1'b0);
    check("vl0.busy", busy, 1'b0);
    check_perf("vl0");
    drive(1'b1, 1'b1, 64'hD1, 6'd3, 3'd1);
    cycle();
    exp_vec++;
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    check_out("vl1", 64'hD1, 1'b1, 6'd3, 2'd0, 1'b1);
    check("vl1.busy", busy, 1'b0);
    check_perf("vl1");
    cycle();
    check("vl1_drain.valid", out_valid, 1'b0);

    // vl=7 clamps to four lanes
    drive(1'b1, 1'b1, 64'hE0, 6'd11, 3'd7);
    cycle();
    exp_vec++;
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("vl7.lane%0d", k), 64'hE0, 1'b1, 6'd11, 2'(k), k == 3);
      cycle();
    end
    check("vl7_drain.valid", out_valid, 1'b0);
    check("vl7_drain.busy", busy, 1'b0);
    check_perf("vl7");

    // asynchronous reset during lane 1 of a vl=4 instruction
    drive(1'b1, 1'b1, 64'hF0, 6'd13, 3'd4);
    cycle();
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    cycle();
    check_out("abort.lane1", 64'hF0, 1'b1, 6'd13, 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_vec   = 0;
    exp_stall = 0;
    check_reset_state("abort");
    #3;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("abort.idle%0d.valid", k), out_valid, 1'b0);
      check($sformatf("abort.idle%0d.busy", k), busy, 1'b0);
    end
    drive(1'b1, 1'b0, 64'h55, 6'd1, 3'd0);
    #1;
    check("after_abort.in_ready", in_ready, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 64'd0, '0, '0);
    check_out("after_abort", 64'h55, 1'b0, 6'd1, 2'd0, 1'b1);
    check_perf("after_abort");
    cycle();
    check("after_abort_drain.valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_vec_lane_sequencer.md
# vx_vec_lane_sequencer

Splits each issued instruction into one or more dispatch packets for the dispatch interface, one per destination vector lane, and drives `vd_lane_id`/`vd_is_last` on the `EXT_V_ENABLE` fields. Scalar instructions pass through as a single packet. Sits directly upstream of the dispatch interface master port, between operand collection and the execute-unit dispatch. The output is a registered single-entry stage with a valid/ready handshake.

## Interface
- `NUM_LANES`, 4: maximum lane packets per vector instruction (≥2).
- `LANE_W`, `$clog2(NUM_LANES)`: lane-id width (matches `LANEID_BITS`).
- `DATA_W`, 64: opaque payload width (uuid…rs3_data packed, not interpreted).
- `NR_W`, 6: register-index width (`NR_BITS`).

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream packet valid.
- `in_ready`  out  1  upstream packet accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W  opaque payload.
- `in_is_vec`  in  1  vector instruction.
- `in_vd`  in  NR_W  vector destination register.
- `in_vl`  in  LANE_W+1  lane count; valid range 0..NUM_LANES.
- `out_valid`  out  1  dispatch packet valid.
- `out_ready`  in  1  dispatch consumer ready.
- `out_data`  out  DATA_W  payload copy.
- `out_is_vec`  out  1  copy of `in_is_vec`.
- `out_vd`  out  NR_W  copy of `in_vd`, constant for all lanes.
- `out_vd_lane_id`  out  LANE_W  lane index of this packet.
- `out_vd_is_last`  out  1  final packet of the instruction.
- `busy`  out  1  state is SEQ.
- `perf_vec_instrs`  out  32  count of accepted vector instructions.
- `perf_stall_cycles`  out  32  count of cycles with `out_valid && !out_ready`.

## Operation
- The state machine has two states. IDLE is the reset state. SEQ is the state for an in-progress vector instruction.
- A single output register holds `out_*`. The output slot is free when `!out_valid || out_ready`.
- In IDLE, `in_ready` = slot free. In SEQ, `in_ready` = 0. While `reset_n` is low, `in_ready` = 0.
- On an accept in IDLE:
  - Scalar packet (`in_is_vec`=0): load the output register with lane_id=0 and is_last=1. State stays IDLE. `in_vl` is ignored.
  - Vector packet with `in_vl`=0: the packet is consumed and no output is produced. State stays IDLE and the output register is unchanged. `perf_vec_instrs` does not increment.
  - Vector packet with `in_vl`=1: load lane 0 with is_last=1. State stays IDLE.
  - Vector packet with `in_vl`≥2: load lane 0 with is_last=0. Latch payload, vd and vl into holding registers. Set `lane_cnt`=1 and go to SEQ.
  - Vector packet with `in_vl`>NUM_LANES: clamp to NUM_LANES.
- In SEQ, on every cycle where the slot is free:
  - Load the output register with the held payload and lane_id=`lane_cnt`.
  - Set is_last = (`lane_cnt` == vl−1).
  - If this is the last lane, go to IDLE. Otherwise increment `lane_cnt`.
- If `out_valid` is high and `out_ready` is low, every `out_*` field holds stable.
- Perf counters wrap modulo 2^32.

## Timing
- Reset values: `out_valid`=0, `out_vd_is_last`=0, `out_vd_lane_id`=0, `out_data`/`out_vd`/`out_is_vec`=0, `busy`=0, both perf counters=0, state IDLE.
- Latency: accept at cycle N gives `out_valid` at cycle N+1.
- Throughput with `out_ready` held high:
  - Scalar packets: 1 per cycle.
  - A vector instruction occupies exactly vl consecutive output cycles.
  - The next instruction is accepted in the same cycle the last lane is consumed, with no bubble.
- The lane with lane_id k for k≥1 appears exactly one cycle after lane k−1 is consumed.
- `reset_n` asserted mid-SEQ aborts the instruction immediately and asynchronously. Remaining lanes are dropped and all outputs return to their reset values.

## Configuration
- `VX_VEC_SEQ_PERF_EN`:
  - Defined: both perf counters are implemented as described.
  - Undefined: the counters are not instantiated, the `perf_*` ports remain present and are tied to 0, and all other behaviour is identical.

## Test plan
- Reset, then 3 back-to-back scalar packets with `out_ready`=1 -> outputs on cycles 1,2,3, each with lane_id=0 and is_last=1; `in_ready` stays 1.
- Vector, vl=4, vd=5, `out_ready`=1 -> 4 consecutive packets with lane_id 0,1,2,3, is_last only on lane 3, vd=5 on all; `busy`=1 for 3 cycles; a scalar offered meanwhile is accepted on the lane-3 consume cycle.
- Vector, vl=3, with `out_ready` low for 2 cycles during lane 1 -> lane 1 is held stable; `perf_stall_cycles`=2; then lane 2 is emitted with is_last=1.
- Vector with vl=0, then vl=1 -> the first produces no output; the second gives a single packet with lane 0 and is_last=1; `perf_vec_instrs`=1.
- Vector, vl=7 with NUM_LANES=4 -> exactly 4 packets, last lane_id=3.
- `reset_n` pulsed low during lane 1 of a vl=4 instruction -> `out_valid`=0 at once and no further lanes are emitted; the next scalar packet behaves normally.
